d_uncache_ctrl: RTL and testbench

D_UNCACHE_CTRL -- requirements
Module: d_uncache_ctrl

---
 rtl/d_uncache_ctrl_pkg.sv | 29 ++
 rtl/d_uncache_ctrl.sv | 133 +++++++++++++
 tb/tb_d_uncache_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_uncache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// d_uncache_ctrl_pkg
// Shared memory-subsystem definitions for the uncached data-access path:
// access size codes, controller state encoding and the latched bus request.
// ---------------------------------------------------------------------------
package d_uncache_ctrl_pkg;

  // Access size codes, shared by the CPU side and the SRAM-like bus side.
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One outstanding bus request; the bus side is driven only from this.
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/d_uncache_ctrl.sv
// ---------------------------------------------------------------------------
// d_uncache_ctrl
// Uncached data-access controller between the MEM stage and an SRAM-like bus.
// Stores are posted (the pipeline keeps running while they drain); loads
// stall the pipeline until the read data returns, which is then presented on
// cpu_rdata for exactly one unstalled DONE cycle. One transaction at a time.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cpu_en              MEM-stage uncached access valid
//   cpu_wen[3:0]        byte enables; nonzero = store, zero = load
//   cpu_size[1:0]       access size (SIZE_B / SIZE_H / SIZE_W)
//   cpu_paddr[31:0]     physical address
//   cpu_wdata[31:0]     lane-aligned store data
//   cpu_rdata[31:0]     raw load word, held until the next load completes
//   cpu_stall           freeze pipeline
//   bus_req             request valid (held until bus_addr_ok)
//   bus_wr              1 = write
//   bus_size[1:0]       access size
//   bus_addr[31:0]      physical address
//   bus_wdata[31:0]     write data
//   bus_wstrb[3:0]      byte strobes, zero on reads
//   bus_addr_ok         request accepted
//   bus_data_ok         read data valid / write complete
//   bus_rdata[31:0]     read data
// ---------------------------------------------------------------------------
module d_uncache_ctrl
  import d_uncache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_paddr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  req_t        req;
  logic        req_valid;
  logic [31:0] rdata_q;
  logic        is_load;

  assign is_load = (cpu_wen == 4'b0000);

  // Stall covers a load being issued in IDLE and any access that arrives
  // while the bus is busy, so the next access waits for the previous one
  // to finish and bus order follows program order. DONE never stalls.
  // NOTE: every always_comb output gets a default first so no path through
  // the block leaves it unassigned and infers a latch.
  always_comb begin
    cpu_stall = 1'b0;
    if (cpu_en) begin
      unique case (state)
        ST_IDLE: cpu_stall = is_load;
        ST_REQ,
        ST_RESP: cpu_stall = 1'b1;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the request register is reset as well because it drives the
      // bus pins directly; an abandoned transaction must leave no residue.
      state     <= ST_IDLE;
      req       <= '0;
      req_valid <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cpu_en) begin
            req <= '{wr:    !is_load,
                     size:  cpu_size,
                     addr:  cpu_paddr,
                     wdata: cpu_wdata,
                     wstrb: cpu_wen};
            req_valid <= 1'b1;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A data_ok seen here belongs to nothing we issued; ignore it.
          if (bus_addr_ok) begin
            req_valid <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus_data_ok) begin
            if (req.wr) begin
              state <= ST_IDLE;
            end else begin
              rdata_q <= bus_rdata;
              state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // One unstalled cycle lets the pipeline consume the load result
          // without the still-asserted cpu_en re-issuing the same load.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus_req   = req_valid;
  assign bus_wr    = req.wr;
  assign bus_size  = req.size;
  assign bus_addr  = req.addr;
  assign bus_wdata = req.wdata;
  assign bus_wstrb = req.wstrb;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_d_uncache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_d_uncache_ctrl
// Directed bench for d_uncache_ctrl. Stimulus tasks push the expected bus
// requests and load results into queues; independent monitors pop and
// compare whenever the DUT shows a bus handshake or a completed load.
// A bus responder model grants addr_ok/data_ok after programmable delays.
// ---------------------------------------------------------------------------
module tb_d_uncache_ctrl;
  import d_uncache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_paddr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  // Responder controls
  logic        auto_bus    = 1'b1;
  logic        early_dok   = 1'b0;
  int          addr_delay  = 0;
  int          data_delay  = 0;
  logic [31:0] rd_word     = '0;
  logic        auto_addr_ok = 1'b0;
  logic        auto_data_ok = 1'b0;
  logic        man_addr_ok  = 1'b0;
  logic        man_data_ok  = 1'b0;
  logic [31:0] resp_rdata   = '0;

  assign bus_addr_ok = auto_addr_ok | man_addr_ok;
  assign bus_data_ok = auto_data_ok | man_data_ok;
  assign bus_rdata   = resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  req_t        exp_bus_q[$];
  logic [31:0] exp_rd_q[$];

  d_uncache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_size    (cpu_size),
    .cpu_paddr   (cpu_paddr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wstrb   (bus_wstrb),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus responder: drives just after each rising edge.
  always begin
    int  acnt;
    int  dcnt;
    logic pend;
    acnt = 0; dcnt = 0; pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      auto_addr_ok = 1'b0;
      auto_data_ok = 1'b0;
      if (!auto_bus || rst) begin
        acnt = 0; dcnt = 0; pend = 1'b0;
      end else if (pend) begin
        if (dcnt == data_delay) begin
          auto_data_ok = 1'b1;
          resp_rdata   = rd_word;
          pend = 1'b0;
          dcnt = 0;
        end else begin
          dcnt++;
        end
      end else if (bus_req) begin
        if (acnt == addr_delay) begin
          auto_addr_ok = 1'b1;
          acnt = 0;
          pend = 1'b1;
        end else begin
          acnt++;
          if (early_dok) begin
            auto_data_ok = 1'b1;
            resp_rdata   = 32'hDEAD_BEEF;
          end
        end
      end
    end
  end

  // Monitor: every bus handshake must match the next expected request.
  always @(negedge clk) begin
    if (!rst && bus_req && bus_addr_ok) begin
      if (exp_bus_q.size() == 0) begin
        check("bus_unexpected_req", 32'(exp_bus_q.size()), 32'd1);
      end else begin
        req_t e;
        e = exp_bus_q.pop_front();
        check("bus_wr",    32'(bus_wr),    32'(e.wr));
        check("bus_size",  32'(bus_size),  32'(e.size));
        check("bus_addr",  bus_addr,       e.addr);
        check("bus_wstrb", 32'(bus_wstrb), 32'(e.wstrb));
        if (e.wr) check("bus_wdata", bus_wdata, e.wdata);
      end
    end
  end

  // Monitor: an unstalled load with cpu_en high can only be the DONE cycle.
  always @(negedge clk) begin
    if (!rst && cpu_en && cpu_wen == 4'b0000 && !cpu_stall) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_unexpected", 32'(exp_rd_q.size()), 32'd1);
      end else begin
        check("cpu_rdata", cpu_rdata, exp_rd_q.pop_front());
      end
    end
  end

  // Hold the access until the pipeline is released; entered and left just
  // after a rising edge with cpu_en still driven.
  task automatic run_access(input string name, output int stalls, output int req_cycles);
    logic done;
    done = 1'b0; stalls = 0; req_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_req) req_cycles++;
      if (!cpu_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      tick();
    end
    check({name, "_completed"}, 32'(done), 32'd1);
    tick();
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] data, output int stalls, output int req_cycles);
    exp_bus_q.push_back('{wr: 1'b0, size: size, addr: addr, wdata: 32'h0, wstrb: 4'h0});
    exp_rd_q.push_back(data);
    rd_word   = data;
    cpu_en    = 1'b1;
    cpu_wen   = 4'b0000;
    cpu_size  = size;
    cpu_paddr = addr;
    cpu_wdata = 32'h0;
    run_access("load", stalls, req_cycles);
  endtask

  task automatic issue_store(input logic [31:0] addr, input logic [1:0] size,
                             input logic [3:0] wen, input logic [31:0] data, output int stalls);
    int rc;
    exp_bus_q.push_back('{wr: 1'b1, size: size, addr: addr, wdata: data, wstrb: wen});
    cpu_en    = 1'b1;
    cpu_wen   = wen;
    cpu_size  = size;
    cpu_paddr = addr;
    cpu_wdata = data;
    run_access("store", stalls, rc);
  endtask

  task automatic drain();
    cpu_en = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    int st;
    int rc;
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = '0; cpu_size = '0;
    cpu_paddr = '0; cpu_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_bus_req",   32'(bus_req),   32'd0);
    check("rst_cpu_rdata", cpu_rdata,      32'd0);
    check("rst_bus_addr",  bus_addr,       32'd0);
    check("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    tick();

    // Minimum-latency word load.
    addr_delay = 0; data_delay = 0;
    issue_load(32'h1FAF_F020, SIZE_W, 32'h1234_5678, st, rc);
    check("load_min_stalls",  32'(st), 32'd3);
    check("load_min_req_cyc", 32'(rc), 32'd1);
    drain();

    // Posted halfword store: no stall, request visible next cycle.
    issue_store(32'h1FAF_F000, SIZE_H, 4'b0011, 32'h0000_BEEF, st);
    cpu_en = 1'b0;
    check("store_stalls", 32'(st), 32'd0);
    @(negedge clk);
    check("store_bus_req",   32'(bus_req),   32'd1);
    check("store_bus_wr",    32'(bus_wr),    32'd1);
    check("store_bus_wstrb", 32'(bus_wstrb), 32'd3);
    check("stall_no_en",     32'(cpu_stall), 32'd0);
    tick();
    drain();
    check("rdata_held", cpu_rdata, 32'h1234_5678);

    // Byte load with slow address and data phases.
    addr_delay = 1; data_delay = 2;
    issue_load(32'h1FAF_F013, SIZE_B, 32'h0000_00A5, st, rc);
    check("load_slow_stalls", 32'(st), 32'd6);
    drain();

    // Store immediately followed by a load, slow address acceptance.
    addr_delay = 4; data_delay = 0;
    issue_store(32'h1FAF_F040, SIZE_W, 4'b1111, 32'hA5A5_5A5A, st);
    check("b2b_store_stalls", 32'(st), 32'd0);
    issue_load(32'h1FAF_F040, SIZE_W, 32'h5A5A_A5A5, st, rc);
    check("b2b_load_stalls", 32'(st), 32'd13);
    drain();

    // data_ok raised while still in REQ must be ignored.
    addr_delay = 2; data_delay = 0; early_dok = 1'b1;
    issue_load(32'h1FAF_F080, SIZE_W, 32'h0BAD_F00D, st, rc);
    check("early_dok_stalls", 32'(st), 32'd5);
    early_dok = 1'b0;
    drain();

    // Byte store on the upper lane.
    addr_delay = 0;
    issue_store(32'h1FAF_F003, SIZE_B, 4'b1000, 32'h7700_0000, st);
    check("byte_store_stalls", 32'(st), 32'd0);
    drain();

    // Reset during RESP of a load, then a stray data_ok.
    auto_bus = 1'b0;
    exp_bus_q.push_back('{wr: 1'b0, size: SIZE_W, addr: 32'h1FAF_F0C0, wdata: 32'h0, wstrb: 4'h0});
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_size = SIZE_W; cpu_paddr = 32'h1FAF_F0C0;
    tick();
    man_addr_ok = 1'b1;
    @(negedge clk);
    check("rstx_bus_req_req", 32'(bus_req), 32'd1);
    tick();
    man_addr_ok = 1'b0;
    @(negedge clk);
    check("rstx_resp_stall",  32'(cpu_stall), 32'd1);
    check("rstx_resp_bus_req", 32'(bus_req),  32'd0);
    tick();
    rst = 1'b1; cpu_en = 1'b0;
    tick();
    rst = 1'b0; resp_rdata = 32'hFFFF_0000; man_data_ok = 1'b1;
    @(negedge clk);
    check("rstx_bus_req",   32'(bus_req), 32'd0);
    check("rstx_cpu_rdata", cpu_rdata,    32'd0);
    check("rstx_bus_addr",  bus_addr,     32'd0);
    tick();
    man_data_ok = 1'b0;
    @(negedge clk);
    check("rstx_late_dok_rdata", cpu_rdata,    32'd0);
    check("rstx_late_dok_req",   32'(bus_req), 32'd0);
    tick();
    auto_bus = 1'b1;

    // Controller is back in IDLE: a fresh load runs at minimum latency.
    addr_delay = 0; data_delay = 0;
    issue_load(32'h1FAF_F100, SIZE_W, 32'hC001_D00D, st, rc);
    check("post_rst_stalls", 32'(st), 32'd3);
    drain();

    check("bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
    check("rd_q_empty",  32'(exp_rd_q.size()),  32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
